// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- read-side handshake of the UART receive FIFO.
//   rd_en   : pop the head entry (driven by the consumer)
//   rd_data : head byte, first-word-fall-through
//   empty   : FIFO holds no bytes
//   full    : FIFO holds DEPTH bytes
// Modports: master = consumer side, slave = the receiver/FIFO block.
interface uart_rx_fifo_if;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;

    modport master (output rd_en, input rd_data, empty, full);
    modport slave  (input rd_en, output rd_data, empty, full);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined) feeding a first-word-fall-through FIFO with sticky error flags.
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   ena         : receiver runs when high; low holds the FSM in IDLE
//   rxd         : asynchronous serial line, idle high
//   err_clr     : clear sticky error flags
//   fifo        : read-side handshake (rd_en, rd_data, empty, full)
//   overrun     : sticky, byte dropped because the FIFO was full
//   frame_err   : sticky, stop bit sampled low
//   parity_err  : sticky, even-parity mismatch (tied 0 without the macro)
//
// Build option: define UART_RX_PARITY_EN to add one even-parity bit
// between data bit 7 and the stop bit.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          rxd,
    input  logic          err_clr,
    uart_rx_fifo_if.slave fifo,
    output logic          overrun,
    output logic          frame_err,
    output logic          parity_err
);
    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    // ------------------------------------------------------------------
    // Synchronizer; rxd_prev is one more stage used only for edge detect.
    // Flops reset to 1 so a reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rxd_meta, rxd_sync, rxd_prev;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t      state;
    logic [11:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        half_tick, bit_tick;

    assign half_tick = (baud_cnt == HALF_LAST);
    assign bit_tick  = (baud_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (!ena) begin
            // Abort: partial byte is simply overwritten by the next frame.
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (half_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        // Line back high at mid start bit: glitch, no flag.
                        state    <= rxd_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rxd_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        state    <= rxd_sync ? IDLE : BREAK;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                BREAK: begin
                    if (rxd_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample-point events, decoded from registered state so the byte lands
    // in the FIFO on the same edge as the stop-bit sample.
    logic push_evt, frame_evt;
    assign push_evt  = ena && (state == STOP) && bit_tick &&  rxd_sync;
    assign frame_evt = ena && (state == STOP) && bit_tick && !rxd_sync;

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty_i, full_i, do_push, do_pop;

    assign empty_i = (count == '0);
    assign full_i  = (count == CW'(DEPTH));
    assign do_pop  = fifo.rd_en && !empty_i;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push_evt && (!full_i || do_pop);

    assign fifo.empty   = empty_i;
    assign fifo.full    = full_i;
    assign fifo.rd_data = empty_i ? 8'h00 : mem[rd_ptr];

    // NOTE: storage array has no reset; validity is tracked by count, and
    // leaving it unreset lets it map onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_reg;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a setting event outranks err_clr in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_evt && full_i && !do_pop) overrun <= 1'b1;
            else if (err_clr)                  overrun <= 1'b0;

            if (frame_evt)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the eight data bits.
    logic parity_evt;
    assign parity_evt = ena && (state == PARITY) && bit_tick &&
                        (rxd_sync != ^shift_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          parity_err <= 1'b0;
        else if (parity_evt) parity_err <= 1'b1;
        else if (err_clr)    parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed bench for uart_rx_fifo (CLKS_PER_BIT=8,
// DEPTH=4). Stimulus queues each byte expected to reach the FIFO; a
// monitor compares the head byte against the queue on every accepted pop.
module tb_uart_rx_fifo;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic rxd = 1'b1;
    logic err_clr = 1'b0;
    logic overrun, frame_err, parity_err;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rxd        (rxd),
        .err_clr    (err_clr),
        .fifo       (bus),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a pop happens at the next rising edge when rd_en && !empty.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.rd_en && !bus.empty) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no data",
                             bus.rd_data);
                end else begin
                    check("pop_data", {24'h0, bus.rd_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Full frame. The stop sample lands on the 7th rising edge after the stop
    // bit is driven (2-flop sync + edge detect + half-bit start alignment).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic bad_par, input bit lat_chk,
                              input bit pop_at_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ bad_par);
`else
        if (bad_par) rxd = 1'b1;
`endif
        rxd = stop_bit;
        repeat (6) @(negedge clk);
        if (lat_chk) check("empty_before_stop_sample", {31'h0, bus.empty}, 32'h1);
        if (pop_at_stop) bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (lat_chk) begin
            check("empty_after_stop_sample", {31'h0, bus.empty}, 32'h0);
            check("rd_data_after_stop_sample", {24'h0, bus.rd_data}, {24'h0, b});
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic read_one();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_empty", {31'h0, bus.empty}, 32'h1);
        check("reset_full", {31'h0, bus.full}, 32'h0);
        check("reset_rd_data", {24'h0, bus.rd_data}, 32'h0);
        check("reset_flags", {29'h0, overrun, frame_err, parity_err}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic byte with latency check, then pop back to empty.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        read_one();
        check("a5_empty_after_pop", {31'h0, bus.empty}, 32'h1);

        // rd_en on an empty FIFO is ignored.
        read_one();
        check("empty_pop_empty", {31'h0, bus.empty}, 32'h1);
        check("empty_pop_full", {31'h0, bus.full}, 32'h0);

        // 3-cycle glitch is rejected; the next frame is received normally.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_empty", {31'h0, bus.empty}, 32'h1);
        check("glitch_flags", {29'h0, overrun, frame_err, parity_err}, 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        read_one();

        // ena dropped mid-frame discards the partial byte.
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        ena = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_empty", {31'h0, bus.empty}, 32'h1);
        check("abort_frame_err", {31'h0, frame_err}, 32'h0);

        // Fill, overflow, clear, then push+pop while full.
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("fill_full", {31'h0, bus.full}, 32'h1);
        check("fill_overrun", {31'h0, overrun}, 32'h0);
        send_frame(8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_overrun", {31'h0, overrun}, 32'h1);
        check("ovf_full", {31'h0, bus.full}, 32'h1);
        pulse_err_clr();
        check("ovf_cleared", {31'h0, overrun}, 32'h0);
        exp_q.push_back(8'h06);
        send_frame(8'h06, 1'b1, 1'b0, 1'b0, 1'b1);
        check("pushpop_full", {31'h0, bus.full}, 32'h1);
        check("pushpop_overrun", {31'h0, overrun}, 32'h0);
        for (int i = 0; i < 4; i++) read_one();
        check("drain_empty", {31'h0, bus.empty}, 32'h1);

        // Stop bit low: frame error, nothing stored; next byte is fine.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ferr_flag", {31'h0, frame_err}, 32'h1);
        check("ferr_empty", {31'h0, bus.empty}, 32'h1);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        check("after_ferr_nonempty", {31'h0, bus.empty}, 32'h0);
        read_one();
        pulse_err_clr();
        check("ferr_cleared", {31'h0, frame_err}, 32'h0);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_bad_flag", {31'h0, parity_err}, 32'h1);
        read_one();
        pulse_err_clr();
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("par_good_flag", {31'h0, parity_err}, 32'h0);
        read_one();
`else
        check("parity_err_tied", {31'h0, parity_err}, 32'h0);
`endif

        // Reset asserted during bit 4 clears FIFO and flags.
        send_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_nonempty", {31'h0, bus.empty}, 32'h0);
        check("pre_rst_ferr", {31'h0, frame_err}, 32'h1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_empty", {31'h0, bus.empty}, 32'h1);
        check("rst_full", {31'h0, bus.full}, 32'h0);
        check("rst_rd_data", {24'h0, bus.rd_data}, 32'h0);
        check("rst_flags", {29'h0, overrun, frame_err, parity_err}, 32'h0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle_empty", {31'h0, bus.empty}, 32'h1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        read_one();

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
